// File: rtl/sram_matmul_engine_if.sv
// Bus bundle for the GEMM engine: job handshake, input/weight SRAM read
// ports and the result SRAM write port. The engine uses the slave view,
// the job controller / memory side uses the master view.
interface sram_matmul_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              dut_valid;
    logic              dut_ready;
    logic [ADDR_W-1:0] res_base_addr;
    logic              dim_err;
    logic [ADDR_W-1:0] in_rd_addr;
    logic [DATA_W-1:0] in_rd_data;
    logic [ADDR_W-1:0] wt_rd_addr;
    logic [DATA_W-1:0] wt_rd_data;
    logic              res_wr_en;
    logic [ADDR_W-1:0] res_wr_addr;
    logic [DATA_W-1:0] res_wr_data;

    modport master (
        output dut_valid, res_base_addr, in_rd_data, wt_rd_data,
        input  dut_ready, dim_err, in_rd_addr, wt_rd_addr,
               res_wr_en, res_wr_addr, res_wr_data
    );

    modport slave (
        input  dut_valid, res_base_addr, in_rd_data, wt_rd_data,
        output dut_ready, dim_err, in_rd_addr, wt_rd_addr,
               res_wr_en, res_wr_addr, res_wr_data
    );
endinterface

// File: rtl/sram_matmul_engine.sv
// Multi-matrix GEMM engine: C_m = A * W_m for m = 0..NUM_MATS-1.
// A (R x K, row-major) comes from input SRAM, each W_m (K x N, column-major)
// from weight SRAM; results are streamed to result SRAM at one MAC per cycle.
// Pipeline: loop counters (RUN) -> registered SRAM addresses -> SRAM data
// one cycle later, where the product is accumulated and, on the last k,
// written out combinationally.
module sram_matmul_engine #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int NUM_MATS = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    sram_matmul_engine_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_CHK   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] A_ZERO   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] A_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] D_ZERO   = {DATA_W{1'b0}};
    localparam logic [15:0]       LAST_MAT = 16'(NUM_MATS - 1);

    state_t            r_state;
    state_t            w_state_next;

    logic              r_ready;
    logic              r_dim_err;
    logic [ADDR_W-1:0] r_in_addr;
    logic [ADDR_W-1:0] r_wt_addr;
    logic [ADDR_W-1:0] r_res_addr;

    // Latched job dimensions
    logic [15:0]       r_rows;
    logic [15:0]       r_kdim;
    logic [15:0]       r_ncols;

    // Loop counters (m outer, k inner) and running address bases
    logic [15:0]       r_m;
    logic [15:0]       r_i;
    logic [15:0]       r_j;
    logic [15:0]       r_k;
    logic [ADDR_W-1:0] r_a_row_base;
    logic [ADDR_W-1:0] r_w_col_base;
    logic [ADDR_W-1:0] r_w_mat_base;

    // Pipeline tags: stage 1 = address on SRAM, stage 2 = data returned
    logic              r_v1;
    logic              r_first1;
    logic              r_last1;
    logic              r_v2;
    logic              r_first2;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_acc;

    logic [15:0]       w_hdr_r;
    logic [15:0]       w_hdr_k;
    logic [15:0]       w_hdr_kw;
    logic [15:0]       w_hdr_n;
    logic              w_dim_mismatch;
    logic              w_dim_zero;
    logic              w_k_last;
    logic              w_j_last;
    logic              w_i_last;
    logic              w_m_last;
    logic              w_issue_last;
    logic              w_accept;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_sum;

    assign w_hdr_r        = bus.in_rd_data[31:16];
    assign w_hdr_k        = bus.in_rd_data[15:0];
    assign w_hdr_kw       = bus.wt_rd_data[31:16];
    assign w_hdr_n        = bus.wt_rd_data[15:0];
    assign w_dim_mismatch = (w_hdr_k != w_hdr_kw);
    assign w_dim_zero     = (w_hdr_r == 16'd0) || (w_hdr_k == 16'd0) || (w_hdr_n == 16'd0);

    assign w_k_last     = (r_k == (r_kdim - 16'd1));
    assign w_j_last     = (r_j == (r_ncols - 16'd1));
    assign w_i_last     = (r_i == (r_rows - 16'd1));
    assign w_m_last     = (r_m == LAST_MAT);
    assign w_issue_last = w_m_last && w_i_last && w_j_last && w_k_last;
    assign w_accept     = (r_state == S_IDLE) && bus.dut_valid;

    // Products and sums wrap modulo 2^DATA_W; k == 0 restarts the dot product.
    assign w_prod = bus.in_rd_data * bus.wt_rd_data;
    assign w_sum  = (r_first2 ? D_ZERO : r_acc) + w_prod;

    assign bus.dut_ready   = r_ready;
    assign bus.dim_err     = r_dim_err;
    assign bus.in_rd_addr  = r_in_addr;
    assign bus.wt_rd_addr  = r_wt_addr;
    assign bus.res_wr_en   = r_wr_en;
    assign bus.res_wr_addr = r_res_addr;
    assign bus.res_wr_data = r_wr_en ? w_sum : D_ZERO;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode for the job sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.dut_valid) begin
                    w_state_next = S_HDR;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_HDR: begin
                w_state_next = S_CHK;
            end
            S_CHK: begin
                if (w_dim_mismatch || w_dim_zero) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_issue_last) begin
                    w_state_next = S_DRAIN;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_DRAIN: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Handshake flags and result write pointer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ready    <= 1'b1;
            r_dim_err  <= 1'b0;
            r_res_addr <= A_ZERO;
        end else begin
            r_ready <= (w_state_next == S_IDLE);
            if (w_accept) begin
                r_dim_err  <= 1'b0;
                r_res_addr <= bus.res_base_addr;
            end else begin
                if ((r_state == S_CHK) && w_dim_mismatch) begin
                    r_dim_err <= 1'b1;
                end
                if (r_wr_en) begin
                    r_res_addr <= r_res_addr + A_ONE;
                end
            end
        end
    end

    // Capture R, K, N from the two header words
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rows  <= 16'd0;
            r_kdim  <= 16'd0;
            r_ncols <= 16'd0;
        end else if (r_state == S_CHK) begin
            r_rows  <= w_hdr_r;
            r_kdim  <= w_hdr_k;
            r_ncols <= w_hdr_n;
        end
    end

    // Loop counters and SRAM address generation; bases advance incrementally
    // so no multiplier is needed for index math. W matrices are contiguous,
    // so the column base simply keeps advancing by K across j and m.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_addr    <= A_ZERO;
            r_wt_addr    <= A_ZERO;
            r_m          <= 16'd0;
            r_i          <= 16'd0;
            r_j          <= 16'd0;
            r_k          <= 16'd0;
            r_a_row_base <= A_ONE;
            r_w_col_base <= A_ONE;
            r_w_mat_base <= A_ONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.dut_valid) begin
                        r_in_addr <= A_ZERO;
                        r_wt_addr <= A_ZERO;
                    end
                end
                S_CHK: begin
                    r_m          <= 16'd0;
                    r_i          <= 16'd0;
                    r_j          <= 16'd0;
                    r_k          <= 16'd0;
                    r_a_row_base <= A_ONE;
                    r_w_col_base <= A_ONE;
                    r_w_mat_base <= A_ONE;
                end
                S_RUN: begin
                    r_in_addr <= r_a_row_base + ADDR_W'(r_k);
                    r_wt_addr <= r_w_col_base + ADDR_W'(r_k);
                    if (!w_k_last) begin
                        r_k <= r_k + 16'd1;
                    end else begin
                        r_k <= 16'd0;
                        if (!w_j_last) begin
                            r_j          <= r_j + 16'd1;
                            r_w_col_base <= r_w_col_base + ADDR_W'(r_kdim);
                        end else begin
                            r_j <= 16'd0;
                            if (!w_i_last) begin
                                r_i          <= r_i + 16'd1;
                                r_a_row_base <= r_a_row_base + ADDR_W'(r_kdim);
                                r_w_col_base <= r_w_mat_base;
                            end else begin
                                r_i          <= 16'd0;
                                r_m          <= r_m + 16'd1;
                                r_a_row_base <= A_ONE;
                                r_w_col_base <= r_w_col_base + ADDR_W'(r_kdim);
                                r_w_mat_base <= r_w_col_base + ADDR_W'(r_kdim);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pipeline tags follow each address to its data; accumulate on return
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_v1     <= 1'b0;
            r_first1 <= 1'b0;
            r_last1  <= 1'b0;
            r_v2     <= 1'b0;
            r_first2 <= 1'b0;
            r_wr_en  <= 1'b0;
            r_acc    <= D_ZERO;
        end else begin
            r_v1     <= (r_state == S_RUN);
            r_first1 <= (r_k == 16'd0);
            r_last1  <= w_k_last;
            r_v2     <= r_v1;
            r_first2 <= r_first1;
            r_wr_en  <= r_v1 && r_last1;
            if (r_v2) begin
                r_acc <= w_sum;
            end
        end
    end

endmodule

// File: tb/tb_sram_matmul_engine.sv
// Self-checking bench for sram_matmul_engine: directed tables, hand-written
// multi-cycle sequences and random jobs checked against a plain-arithmetic
// GEMM reference model working directly on the memory layout.
module tb_sram_matmul_engine;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int NM     = 3;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    sram_matmul_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    sram_matmul_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_MATS(NM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models, 1-cycle read latency
    logic [31:0] in_mem [0:1023];
    logic [31:0] wt_mem [0:1023];
    always @(posedge clk) begin
        bus.in_rd_data <= in_mem[bus.in_rd_addr[9:0]];
        bus.wt_rd_data <= wt_mem[bus.wt_rd_addr[9:0]];
    end

    // Result-port monitor
    logic [15:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          cap_cyc[$];
    int          wr_total = 0;
    int          idle_data_bad = 0;
    always @(negedge clk) begin
        if (bus.res_wr_en === 1'b1) begin
            cap_addr.push_back(bus.res_wr_addr);
            cap_data.push_back(bus.res_wr_data);
            cap_cyc.push_back(cyc);
            wr_total <= wr_total + 1;
        end else if (bus.res_wr_data !== 32'd0) begin
            idle_data_bad <= idle_data_bad + 1;
        end
    end

    // Expected results
    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_dim;
    int          exp_k;
    int          exp_macs;
    int          t_acc;
    int          t_done;

    logic [31:0] t1_exp [12] = '{32'd1, 32'd2, 32'd3, 32'd4,
                                 32'd2, 32'd4, 32'd6, 32'd8,
                                 32'd3, 32'd3, 32'd7, 32'd7};

    typedef struct {
        logic [31:0] a;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
    } k1_vec_t;

    typedef struct {
        logic [31:0] in_hdr;
        logic [31:0] wt_hdr;
        logic        dim;
    } hdr_vec_t;

    k1_vec_t  k1_tab [4];
    hdr_vec_t hdr_tab [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference GEMM straight from the memory layout rules
    task automatic model_job(input logic [15:0] base);
        int r, k, kw, n;
        logic [31:0] acc;
        exp_addr.delete();
        exp_data.delete();
        r  = int'(in_mem[0][31:16]);
        k  = int'(in_mem[0][15:0]);
        kw = int'(wt_mem[0][31:16]);
        n  = int'(wt_mem[0][15:0]);
        exp_dim  = (k != kw);
        exp_k    = k;
        exp_macs = NM * r * n * k;
        if (!exp_dim && r > 0 && k > 0 && n > 0) begin
            for (int m = 0; m < NM; m++)
                for (int i = 0; i < r; i++)
                    for (int j = 0; j < n; j++) begin
                        acc = 32'd0;
                        for (int kk = 0; kk < k; kk++)
                            acc = acc + in_mem[1 + i*k + kk] * wt_mem[1 + m*k*n + j*k + kk];
                        exp_addr.push_back(base + 16'(m*r*n + i*n + j));
                        exp_data.push_back(acc);
                    end
        end
    endtask

    task automatic run_job(input string tag, input logic [15:0] base, input bit poke);
        int guard;
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
        @(negedge clk);
        chk({tag, ".ready_at_start"}, bus.dut_ready, 1);
        bus.dut_valid     = 1'b1;
        bus.res_base_addr = base;
        t_acc = cyc;
        @(negedge clk);
        bus.dut_valid = 1'b0;
        guard = 0;
        while (bus.dut_ready !== 1'b1 && guard < 2000) begin
            bus.dut_valid = poke && guard >= 20 && guard < 23;
            @(negedge clk);
            guard++;
        end
        bus.dut_valid = 1'b0;
        t_done = cyc;
        chk({tag, ".ready_timeout"}, bus.dut_ready, 1);
    endtask

    task automatic check_job(input string tag);
        int n;
        chk({tag, ".count"}, cap_addr.size(), exp_addr.size());
        n = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
        for (int x = 0; x < n; x++) begin
            chk($sformatf("%s.addr[%0d]", tag, x), cap_addr[x], exp_addr[x]);
            chk($sformatf("%s.data[%0d]", tag, x), cap_data[x], exp_data[x]);
        end
        chk({tag, ".dim_err"}, bus.dim_err, exp_dim);
        if (exp_addr.size() > 0) begin
            if (cap_cyc.size() > 0)
                chk({tag, ".first_wr_lat"}, cap_cyc[0] - t_acc, 4 + exp_k);
            chk({tag, ".done_lat"}, t_done - t_acc, 5 + exp_macs);
        end else begin
            chk({tag, ".abort_within4"}, (t_done - t_acc) <= 4, 1);
        end
    endtask

    task automatic load_t1();
        in_mem[0] = 32'h0002_0002;
        in_mem[1] = 32'd1; in_mem[2] = 32'd2; in_mem[3] = 32'd3; in_mem[4] = 32'd4;
        wt_mem[0] = 32'h0002_0002;
        wt_mem[1] = 32'd1; wt_mem[2]  = 32'd0; wt_mem[3]  = 32'd0; wt_mem[4]  = 32'd1;
        wt_mem[5] = 32'd2; wt_mem[6]  = 32'd0; wt_mem[7]  = 32'd0; wt_mem[8]  = 32'd2;
        wt_mem[9] = 32'd1; wt_mem[10] = 32'd1; wt_mem[11] = 32'd1; wt_mem[12] = 32'd1;
    endtask

    task automatic t1_job(input string tag, input logic [15:0] base);
        load_t1();
        exp_addr.delete();
        exp_data.delete();
        for (int x = 0; x < 12; x++) begin
            exp_addr.push_back(base + 16'(x));
            exp_data.push_back(t1_exp[x]);
        end
        exp_dim  = 1'b0;
        exp_k    = 2;
        exp_macs = 24;
        run_job(tag, base, 1'b0);
        check_job(tag);
    endtask

    task automatic rand_job(input string tag, input int r, input int k, input int n,
                            input logic [15:0] base, input bit poke);
        in_mem[0] = {16'(r), 16'(k)};
        wt_mem[0] = {16'(k), 16'(n)};
        for (int x = 1; x <= r*k; x++) in_mem[x] = $urandom;
        for (int x = 1; x <= NM*k*n; x++) wt_mem[x] = $urandom;
        model_job(base);
        run_job(tag, base, poke);
        check_job(tag);
    endtask

    initial begin
        int w;
        k1_tab[0] = '{32'h0001_0000, 32'h0001_0000, 32'd3, 32'hFFFF_FFFF,
                      32'h0000_0000, 32'h0003_0000, 32'hFFFF_0000};
        k1_tab[1] = '{32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFB, 32'd0,
                      32'hFFFF_FFF1, 32'h0000_000F, 32'h0000_0000};
        k1_tab[2] = '{32'h8000_0000, 32'd2, 32'd1, 32'hFFFF_FFFF,
                      32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
        k1_tab[3] = '{32'h1234_5678, 32'h10, 32'hFFFF_FFFF, 32'd7,
                      32'h2345_6780, 32'hEDCB_A988, 32'h7F6E_5D48};
        hdr_tab[0] = '{32'h0000_0002, 32'h0002_0002, 1'b0};
        hdr_tab[1] = '{32'h0002_0002, 32'h0002_0000, 1'b0};
        hdr_tab[2] = '{32'h0002_0000, 32'h0000_0002, 1'b0};
        hdr_tab[3] = '{32'h0002_0003, 32'h0002_0002, 1'b1};

        for (int x = 0; x < 1024; x++) begin
            in_mem[x] = 32'd0;
            wt_mem[x] = 32'd0;
        end
        reset_n           = 1'b0;
        bus.dut_valid     = 1'b0;
        bus.res_base_addr = 16'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst.dut_ready",   bus.dut_ready,   1);
        chk("rst.dim_err",     bus.dim_err,     0);
        chk("rst.res_wr_en",   bus.res_wr_en,   0);
        chk("rst.in_rd_addr",  bus.in_rd_addr,  0);
        chk("rst.wt_rd_addr",  bus.wt_rd_addr,  0);
        chk("rst.res_wr_addr", bus.res_wr_addr, 0);
        chk("rst.res_wr_data", bus.res_wr_data, 0);
        reset_n = 1'b1;

        // T1: identity / 2I / ones
        t1_job("T1", 16'h0000);

        // T4 and friends: scalar K=1 wrap and sign cases
        for (int v = 0; v < 4; v++) begin
            in_mem[0] = 32'h0001_0001;
            in_mem[1] = k1_tab[v].a;
            wt_mem[0] = 32'h0001_0001;
            wt_mem[1] = k1_tab[v].w0;
            wt_mem[2] = k1_tab[v].w1;
            wt_mem[3] = k1_tab[v].w2;
            exp_addr.delete();
            exp_data.delete();
            for (int x = 0; x < 3; x++) exp_addr.push_back(16'h0010 * 16'(v) + 16'(x));
            exp_data.push_back(k1_tab[v].e0);
            exp_data.push_back(k1_tab[v].e1);
            exp_data.push_back(k1_tab[v].e2);
            exp_dim  = 1'b0;
            exp_k    = 1;
            exp_macs = 3;
            run_job($sformatf("K1[%0d]", v), 16'h0010 * 16'(v), 1'b0);
            check_job($sformatf("K1[%0d]", v));
        end

        // T2/T3: zero dimensions and K mismatch (mismatch last)
        for (int v = 0; v < 4; v++) begin
            in_mem[0] = hdr_tab[v].in_hdr;
            wt_mem[0] = hdr_tab[v].wt_hdr;
            exp_addr.delete();
            exp_data.delete();
            exp_dim = hdr_tab[v].dim;
            run_job($sformatf("HDR[%0d]", v), 16'h0040, 1'b0);
            check_job($sformatf("HDR[%0d]", v));
        end

        // T5: 3x4 * 4x5 at 0x0100 with dut_valid poked while busy
        rand_job("T5", 3, 4, 5, 16'h0100, 1'b1);
        w = wr_total;
        repeat (6) @(negedge clk);
        #1;
        chk("T5.busy_valid_ignored", wr_total, w);
        chk("T5.idle_ready", bus.dut_ready, 1);

        // Random jobs, back to back
        for (int v = 0; v < 4; v++)
            rand_job($sformatf("RND[%0d]", v), $urandom_range(1, 4), $urandom_range(1, 4),
                     $urandom_range(1, 4), 16'($urandom), 1'b0);

        // T6: reset mid-RUN, then a clean rerun with address wrap
        load_t1();
        @(negedge clk);
        bus.dut_valid     = 1'b1;
        bus.res_base_addr = 16'h0200;
        @(negedge clk);
        bus.dut_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        w = wr_total;
        chk("T6.ready_after_rst", bus.dut_ready, 1);
        chk("T6.wr_en_after_rst", bus.res_wr_en, 0);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("T6.no_writes_after_rst", wr_total, w);
        chk("T6.still_ready", bus.dut_ready, 1);
        t1_job("T6.rerun_wrap", 16'hFFFA);
        t1_job("T6.back2back", 16'h0300);

        chk("idle_wr_data_zero", idle_data_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
